// File: rtl/uart_tx_buffer_pkg.sv
// ==========================================================================
// uart_tx_buffer_pkg : MMIO addresses, status bits, output-stage state | Rev 1.0
// ==========================================================================
`default_nettype none

package uart_tx_buffer_pkg;

   localparam logic [31:0] UART_STATUS_ADDR  = 32'h8000_0000;
   localparam logic [31:0] UART_TX_DATA_ADDR = 32'h8000_0008;

   localparam int TX_READY_BIT = 0;
   localparam int TX_OVF_BIT   = 2;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ==========================================================================
// sync_fifo : single-clock FIFO, separate count so full/empty never alias | Rev 1.0
// ==========================================================================
`default_nettype none

module sync_fifo
   import uart_tx_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Full is judged on the pre-pop count, so a push at full is refused even
   // when the same edge pops.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// ==========================================================================
// uart_tx_buffer : FIFO-backed registered write path into the UART TX | Rev 1.0
// ==========================================================================
`default_nettype none

module uart_tx_buffer
   import uart_tx_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       clr_overflow,
   output logic                       tx_ready,
   output logic                       tx_idle,
   output logic [$clog2(DEPTH+1)-1:0] tx_level,
   output logic                       overflow,
   output logic [7:0]                 uart_din,
   output logic                       uart_din_valid,
   input  logic                       uart_din_ready
);

   logic [7:0]                 w_fifo_data;
   logic                       w_full;
   logic                       w_empty;
   logic [$clog2(DEPTH+1)-1:0] w_count;
   logic                       w_load;
   logic                       w_pop;

   stage_state_t               r_state;
   logic [7:0]                 r_din;
   logic                       r_valid;
   logic                       r_ovf;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (wr_en),
      .i_data  (wr_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Ready only gates the load; valid is always a flop.
   assign w_load = (r_state == ST_EMPTY) || uart_din_ready;
   assign w_pop  = w_load && !w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_din   <= 8'h00;
         r_valid <= 1'b0;
      end else if (w_load) begin
         if (!w_empty) begin
            r_state <= ST_HOLD;
            r_din   <= w_fifo_data;
            r_valid <= 1'b1;
         end else begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                  r_ovf <= 1'b0;
      else if (wr_en && w_full) r_ovf <= 1'b1;
      else if (clr_overflow)    r_ovf <= 1'b0;
   end

   assign uart_din       = r_din;
   assign uart_din_valid = r_valid;
   assign overflow       = r_ovf;
   assign tx_level       = w_count;
   assign tx_ready       = !w_full;
   assign tx_idle        = w_empty && !r_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
// Scoreboarded bench for uart_tx_buffer: queue-level reference model, directed
// scenarios followed by randomized write/ready/clear/reset traffic.
`default_nettype none

module tb_uart_tx_buffer;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       clr_overflow = 1'b0;
   logic       uart_din_ready = 1'b0;
   logic       tx_ready;
   logic       tx_idle;
   logic [3:0] tx_level;
   logic       overflow;
   logic [7:0] uart_din;
   logic       uart_din_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bytes waiting in the FIFO, whether a byte sits at the
   // UART boundary, and the sticky flag.  sb_q holds every accepted byte not
   // yet handed to the UART, in send order.
   logic [7:0] m_fifo[$];
   bit         m_stage = 1'b0;
   bit         m_ovf   = 1'b0;
   bit         m_full;
   logic [7:0] sb_q[$];

   bit         mon_en = 1'b0;
   bit         p_hold = 1'b0;
   logic [7:0] p_din  = 8'h00;

   always #5 clk = ~clk;

   uart_tx_buffer #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .clr_overflow   (clr_overflow),
      .tx_ready       (tx_ready),
      .tx_idle        (tx_idle),
      .tx_level       (tx_level),
      .overflow       (overflow),
      .uart_din       (uart_din),
      .uart_din_valid (uart_din_valid),
      .uart_din_ready (uart_din_ready)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_fifo.delete();
         sb_q.delete();
         m_stage = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         m_full = (m_fifo.size() == DEPTH);
         if (!m_stage || uart_din_ready) begin
            if (m_fifo.size() > 0) begin
               void'(m_fifo.pop_front());
               m_stage = 1'b1;
            end else begin
               m_stage = 1'b0;
            end
         end
         if (wr_en && !m_full) begin
            m_fifo.push_back(wr_data);
            sb_q.push_back(wr_data);
         end
         if (wr_en && m_full)   m_ovf = 1'b1;
         else if (clr_overflow) m_ovf = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("level", 32'(tx_level), 32'(m_fifo.size()));
         chk("tx_ready", 32'(tx_ready), 32'(m_fifo.size() != DEPTH));
         chk("tx_idle", 32'(tx_idle), 32'(m_fifo.size() == 0 && !m_stage));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("valid", 32'(uart_din_valid), 32'(m_stage));
         if (p_hold && uart_din_valid === 1'b1)
            chk("din_stable", 32'(uart_din), 32'(p_din));
         if (uart_din_valid === 1'b1 && uart_din_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected_byte", 32'(uart_din), 32'hFFFF_FFFF);
            else                  chk("sb_data", 32'(uart_din), 32'(sb_q.pop_front()));
         end
         p_hold = (uart_din_valid === 1'b1) && !uart_din_ready && !rst;
         p_din  = uart_din;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic drain(input int n);
      uart_din_ready = 1'b1;
      repeat (n) cyc();
   endtask

   initial begin
      // Reset held three edges with a write pending: nothing may be queued.
      rst     = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      cyc();
      mon_en = 1'b1;
      cyc();
      cyc();
      rst   = 1'b0;
      wr_en = 1'b0;
      chk("rst_level", 32'(tx_level), 0);
      chk("rst_ready", 32'(tx_ready), 1);
      chk("rst_idle", 32'(tx_idle), 1);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_din", 32'(uart_din), 0);
      chk("rst_valid", 32'(uart_din_valid), 0);
      cyc();
      chk("rst_no_entry", 32'(tx_level), 0);

      // Single byte: valid two edges after the write, for exactly one cycle.
      uart_din_ready = 1'b1;
      wr(8'h41);
      chk("single_valid_e1", 32'(uart_din_valid), 0);
      cyc();
      chk("single_valid_e2", 32'(uart_din_valid), 1);
      chk("single_din", 32'(uart_din), 32'h41);
      cyc();
      chk("single_valid_e3", 32'(uart_din_valid), 0);
      chk("single_idle", 32'(tx_idle), 1);

      // Backpressure: ten writes, stage + 8 queued, tenth dropped.
      uart_din_ready = 1'b0;
      for (int i = 0; i < 10; i++) wr(8'(i));
      chk("bp_level", 32'(tx_level), 8);
      chk("bp_ready", 32'(tx_ready), 0);
      chk("bp_valid", 32'(uart_din_valid), 1);
      chk("bp_hold", 32'(uart_din), 0);
      chk("bp_ovf", 32'(overflow), 1);
      uart_din_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("bp_order", 32'(uart_din), 32'(i));
         chk("bp_order_valid", 32'(uart_din_valid), 1);
         cyc();
      end
      chk("bp_done", 32'(uart_din_valid), 0);

      // Write at full on the same edge as a pop: rejected, level drops.
      uart_din_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(8'(8'h10 + i));
      chk("sim_level_full", 32'(tx_level), 8);
      uart_din_ready = 1'b1;
      wr(8'hAA);
      chk("sim_level", 32'(tx_level), 7);
      chk("sim_ovf", 32'(overflow), 1);
      drain(12);

      // Overflow clear alone, then clear colliding with an overflowing write.
      clr_overflow = 1'b1;
      cyc();
      clr_overflow = 1'b0;
      chk("clr_ovf", 32'(overflow), 0);
      uart_din_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(8'(8'h20 + i));
      clr_overflow = 1'b1;
      wr(8'hBB);
      clr_overflow = 1'b0;
      chk("clr_vs_set", 32'(overflow), 1);
      drain(12);
      clr_overflow = 1'b1;
      cyc();
      clr_overflow = 1'b0;

      // Reset with five queued bytes and a stalled stage.
      uart_din_ready = 1'b0;
      for (int i = 0; i < 6; i++) wr(8'(8'h30 + i));
      chk("mid_level", 32'(tx_level), 5);
      chk("mid_valid", 32'(uart_din_valid), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(uart_din_valid), 0);
      chk("mid_rst_level", 32'(tx_level), 0);
      uart_din_ready = 1'b1;
      wr(8'h55);
      cyc();
      chk("mid_next_valid", 32'(uart_din_valid), 1);
      chk("mid_next_din", 32'(uart_din), 32'h55);
      cyc();

      // Randomized traffic with varying ready duty cycle.
      for (int blk = 0; blk < 15; blk++) begin
         int ready_pct;
         ready_pct = $urandom_range(0, 100);
         for (int c = 0; c < 200; c++) begin
            rst            = ($urandom_range(0, 399) == 0);
            wr_en          = ($urandom_range(0, 99) < 60);
            wr_data        = 8'($urandom);
            uart_din_ready = ($urandom_range(0, 99) < ready_pct);
            clr_overflow   = ($urandom_range(0, 19) == 0);
            cyc();
         end
      end
      rst          = 1'b0;
      wr_en        = 1'b0;
      clr_overflow = 1'b0;
      drain(DEPTH + 4);
      chk("final_sb_empty", 32'(sb_q.size()), 0);
      chk("final_idle", 32'(tx_idle), 1);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
